axis_rr_arb: RTL and testbench

AXIS_RR_ARB -- requirements
Module: axis_rr_arb

---
 rtl/arb_pkg.sv | 29 ++
 rtl/axis_if.sv | 11 +
 rtl/rr_pick.sv | 36 +++
 rtl/axis_rr_arb.sv | 101 ++++++++++
 tb/tb_axis_rr_arb.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter state encoding and the
// round-robin rotate helper used by rr_pick.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int MAX_SRC = 16;

    // Rotate req so that bit 0 holds index start; bits >= n read as zero.
    function automatic logic [MAX_SRC-1:0] rr_rotate(
        input logic [MAX_SRC-1:0] req,
        input int                 start,
        input int                 n
    );
        logic [MAX_SRC-1:0] rot;
        int                 idx;
        rot = '0;
        for (int k = 0; k < MAX_SRC; k++) begin
            idx = start + k;
            if (idx >= n) idx = idx - n;
            if (k < n) rot[k] = |(req & (MAX_SRC'(1) << idx));
        end
        return rot;
    endfunction

endpackage

// File: rtl/axis_if.sv
// Axis: minimal valid/ready stream bundle.
interface Axis #(
    parameter int W = 32
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport Master (output data, output valid, input ready);
    modport Slave  (input data, input valid, output ready);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after last+1, wrapping modulo N.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    logic [MAX_SRC-1:0] w_req;
    logic [MAX_SRC-1:0] w_rot;
    logic [IW-1:0]      w_start;
    logic [IW-1:0]      w_off;
    logic [IW:0]        w_sum;

    always_comb begin
        w_req        = '0;
        w_req[N-1:0] = i_req;
        w_start      = (i_last == IW'(N - 1)) ? '0 : i_last + 1'b1;
        w_rot        = rr_rotate(w_req, int'(w_start), N);
        w_off        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = IW'(k);
        end
        w_sum = {1'b0, w_start} + {1'b0, w_off};
    end

    assign o_found = |w_rot;
    assign o_idx   = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N))
                                           : w_sum[IW-1:0];

endmodule

// File: rtl/axis_rr_arb.sv
// axis_rr_arb: round-robin stream arbiter, bursts of up to
// MAX_BURST beats per grant through a one-deep output register.
module axis_rr_arb
    import arb_pkg::*;
#(
    parameter  int NUM_SRC   = 4,
    parameter  int BITWIDTH  = 32,
    parameter  int MAX_BURST = 8,
    localparam int IW        = $clog2(NUM_SRC),
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic          clk,
    input  logic          rst,
    Axis.Slave            src [NUM_SRC],
    Axis.Master           dest,
    output logic [IW-1:0] grant_id,
    output logic          busy
);

    arb_state_e           r_state;
    arb_state_e           w_next;
    logic [IW-1:0]        r_grant;
    logic [CW-1:0]        r_cnt;
    logic                 r_dvalid;
    logic [BITWIDTH-1:0]  r_ddata;

    logic [NUM_SRC-1:0]   w_valid;
    logic [NUM_SRC-1:0]   w_ready;
    logic [BITWIDTH-1:0]  w_data [NUM_SRC];
    logic                 w_found;
    logic [IW-1:0]        w_pick;
    logic                 w_gvalid;
    logic                 w_slot;
    logic                 w_accept;
    logic                 w_release;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign w_valid[gi]    = src[gi].valid;
        assign w_data[gi]     = src[gi].data;
        assign src[gi].ready  = w_ready[gi];
    end

    rr_pick #(
        .N (NUM_SRC)
    ) u_pick (
        .i_req   (w_valid),
        .i_last  (r_grant),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_gvalid = w_valid[r_grant];
    assign w_slot   = !r_dvalid || dest.ready;
    assign w_accept = (r_state == GRANT) && w_gvalid && w_slot;
    // Release needs an open slot: a valid drop under stall is ignored.
    assign w_release = (r_state == GRANT) && w_slot &&
                       (!w_gvalid || (r_cnt == CW'(MAX_BURST - 1)));

    always_comb begin
        w_ready = '0;
        if (r_state == GRANT) w_ready[r_grant] = w_slot;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (w_found) w_next = GRANT;
            GRANT: if (w_release) w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_grant  <= IW'(NUM_SRC - 1);
            r_cnt    <= '0;
            r_dvalid <= 1'b0;
            r_ddata  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_found) begin
                r_grant <= w_pick;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_ddata  <= w_data[r_grant];
                r_dvalid <= 1'b1;
            end else if (dest.ready) begin
                r_dvalid <= 1'b0;
            end
        end
    end

    assign dest.valid = r_dvalid;
    assign dest.data  = r_ddata;
    assign grant_id   = r_grant;
    assign busy       = (r_state == GRANT);

endmodule

// File: tb/tb_axis_rr_arb.sv
// tb_axis_rr_arb: vector table, rotation, early release, random
// backpressure scoreboard and mid-burst reset for axis_rr_arb.
module tb_axis_rr_arb;

    localparam int NS = 4;
    localparam int BW = 32;
    localparam int MB = 8;

    typedef struct {
        logic          rst;
        logic [NS-1:0] v;
        logic          dr;
        logic          chk;
        logic          busy;
        logic [1:0]    gid;
        logic [NS-1:0] rdy;
        logic          dv;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          dr;
    logic [1:0]    gid;
    logic          busy;
    logic [NS-1:0] src_v;
    logic [NS-1:0] src_r;
    logic [BW-1:0] src_d [NS];
    logic          dv;
    logic [BW-1:0] dd;

    Axis #(.W(BW)) s_if [NS] ();
    Axis #(.W(BW)) d_if ();

    for (genvar gi = 0; gi < NS; gi++) begin : g_drv
        assign s_if[gi].valid = src_v[gi];
        assign s_if[gi].data  = src_d[gi];
        assign src_r[gi]      = s_if[gi].ready;
    end
    assign d_if.ready = dr;
    assign dv         = d_if.valid;
    assign dd         = d_if.data;

    axis_rr_arb #(
        .NUM_SRC   (NS),
        .BITWIDTH  (BW),
        .MAX_BURST (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src      (s_if),
        .dest     (d_if),
        .grant_id (gid),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [NS-1:0] en;
    int            left   [NS];
    int            sseq   [NS];
    int            eseq   [NS];
    int            hs_cnt [NS];
    int            dcnt   [NS];
    int            n_chk;
    int            n_err;
    bit            chk_on;
    bit            stall_prev;
    bit            rec_on;
    logic [BW-1:0] held;
    int            run_cnt;
    int            run_id;
    logic [BW:0]   rot_log [$];
    vec_t          tbl [14];

    task automatic chk(input string nm, input bit ok,
                       input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic sample();
        int nr;
        int id;
        int sq;
        if (chk_on) begin
            nr = $countones(src_r);
            chk("one_ready", nr <= 1 && (nr == 0 || busy === 1'b1),
                nr, int'(busy === 1'b1));
        end
        if (stall_prev) begin
            chk("hold_valid", dv === 1'b1, int'(dv), 1);
            chk("hold_data", dd === held, int'(dd), int'(held));
        end
        if (rst === 1'b1 && dv === 1'b1 && dr === 1'b1) begin
            id = int'(dd[31:24]);
            sq = int'(dd[23:0]);
            chk("beat_src", id < NS, id, NS - 1);
            if (id < NS) begin
                chk("beat_seq", sq == eseq[id], sq, eseq[id]);
                eseq[id] = sq + 1;
                dcnt[id]++;
            end
        end
        stall_prev = (rst === 1'b1) && (dv === 1'b1) && (dr === 1'b0);
        held = dd;
        if (rec_on) rot_log.push_back({dv === 1'b1, dd});
        for (int i = 0; i < NS; i++) begin
            if (src_v[i] && src_r[i] === 1'b1) begin
                sseq[i]++;
                hs_cnt[i]++;
                if (left[i] > 0) left[i]--;
                if (rst === 1'b1 && busy === 1'b1) begin
                    if (run_cnt > 0) chk("run_src", i == run_id, i, run_id);
                    run_id = i;
                    run_cnt++;
                    chk("run_len", run_cnt <= MB, run_cnt, MB);
                end
            end
        end
        if (busy !== 1'b1) run_cnt = 0;
        if (rst !== 1'b1) begin
            run_cnt = 0;
            for (int i = 0; i < NS; i++) eseq[i] = sseq[i];
        end
    endtask

    task automatic pre();
        for (int i = 0; i < NS; i++) begin
            src_v[i] = en[i] && (left[i] != 0);
            src_d[i] = {8'(i), 24'(sseq[i])};
        end
        #4;
    endtask

    task automatic post();
        sample();
        @(negedge clk);
    endtask

    task automatic cyc();
        pre();
        post();
    endtask

    task automatic do_reset(input logic [NS-1:0] v);
        en  = v;
        rst = 1'b0;
        dr  = 1'b1;
        for (int r = 0; r < 3; r++) begin
            pre();
            if (r > 0) begin
                chk("rst_busy", busy === 1'b0, int'(busy), 0);
                chk("rst_dv", dv === 1'b0, int'(dv), 0);
                chk("rst_rdy", src_r === '0, int'(src_r), 0);
            end
            post();
        end
        rst = 1'b1;
    endtask

    initial begin
        int f;
        int base;
        int t;
        logic [BW:0] e;
        n_chk = 0; n_err = 0; chk_on = 0; stall_prev = 0;
        rec_on = 0; run_cnt = 0; run_id = 0; held = '0;
        for (int i = 0; i < NS; i++) begin
            left[i] = -1; sseq[i] = 0; eseq[i] = 0;
            hs_cnt[i] = 0; dcnt[i] = 0;
        end
        rst = 1'b0; dr = 1'b1; en = '0; src_v = '0;

        tbl[0]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0};
        tbl[1]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0};
        tbl[3]  = '{1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0};
        tbl[4]  = '{1'b1, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0};
        tbl[5]  = '{1'b1, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1};
        tbl[6]  = '{1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b1};
        tbl[7]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b1};
        tbl[8]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1};
        tbl[9]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0};
        tbl[10] = '{1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0};
        tbl[11] = '{1'b1, 4'b1001, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0};
        tbl[12] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1};
        tbl[13] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0};

        @(negedge clk);
        for (int r = 0; r < 14; r++) begin
            if (r == 1) chk_on = 1;
            rst = tbl[r].rst;
            en  = tbl[r].v;
            dr  = tbl[r].dr;
            pre();
            if (tbl[r].chk) begin
                chk("tbl_busy", busy === tbl[r].busy, int'(busy), int'(tbl[r].busy));
                chk("tbl_gid", gid === tbl[r].gid, int'(gid), int'(tbl[r].gid));
                chk("tbl_rdy", src_r === tbl[r].rdy, int'(src_r), int'(tbl[r].rdy));
                chk("tbl_dv", dv === tbl[r].dv, int'(dv), int'(tbl[r].dv));
            end
            post();
        end

        // Rotation: 8 beats per source, one bubble between grants.
        do_reset(4'b1111);
        rec_on = 1;
        repeat (80) cyc();
        rec_on = 0;
        f = -1;
        for (int k = 0; k < rot_log.size(); k++) begin
            e = rot_log[k];
            if (f < 0 && e[BW]) f = k;
        end
        chk("rot_latency", f == 2, f, 2);
        if (f < 0) f = 0;
        for (int k = 0; k < 72; k++) begin
            t = f + k;
            if (t < rot_log.size()) begin
                e = rot_log[t];
                if (k % 9 == 8)
                    chk("rot_bubble", !e[BW], int'(e[BW]), 0);
                else
                    chk("rot_src", e[BW] && int'(e[31:24]) == (k / 9) % NS,
                        int'(e[31:24]), (k / 9) % NS);
            end
        end

        // Early release on a lone source.
        do_reset('0);
        en = 4'b0100;
        left[2] = 3;
        base = dcnt[2];
        repeat (12) cyc();
        chk("early_beats", dcnt[2] - base == 3, dcnt[2] - base, 3);
        chk("early_idle", busy === 1'b0, int'(busy), 0);
        chk("early_gid", gid === 2'd2, int'(gid), 2);
        left[2] = 5;
        repeat (14) cyc();
        chk("regrant_beats", dcnt[2] - base == 8, dcnt[2] - base, 8);
        chk("regrant_idle", busy === 1'b0, int'(busy), 0);

        // Random valid and backpressure against the scoreboard.
        do_reset('0);
        base = 0;
        for (int i = 0; i < NS; i++) base += dcnt[i];
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NS; i++) begin
                if (left[i] <= 0 && $urandom_range(0, 3) == 0)
                    left[i] = $urandom_range(1, 12);
                en[i] = ($urandom_range(0, 7) != 0);
            end
            dr = $urandom_range(0, 1) == 1;
            cyc();
        end
        en = '0;
        dr = 1'b1;
        repeat (20) cyc();
        for (int i = 0; i < NS; i++)
            chk("drain", eseq[i] == sseq[i], eseq[i], sseq[i]);
        t = 0;
        for (int i = 0; i < NS; i++) t += dcnt[i];
        chk("rand_traffic", t - base > 100, t - base, 101);

        // Reset at beat 4 of a src3 grant.
        do_reset('0);
        for (int i = 0; i < NS; i++) left[i] = -1;
        en = 4'b1000;
        base = hs_cnt[3];
        for (int k = 0; k < 20 && hs_cnt[3] - base < 4; k++) cyc();
        chk("burst_beat4", hs_cnt[3] - base == 4, hs_cnt[3] - base, 4);
        rst = 1'b0;
        dr  = 1'b0;
        pre();
        chk("mid_pending", dv === 1'b1, int'(dv), 1);
        post();
        rst = 1'b1;
        dr  = 1'b1;
        en  = 4'b1010;
        pre();
        chk("mid_dv_clr", dv === 1'b0, int'(dv), 0);
        chk("mid_idle", busy === 1'b0, int'(busy), 0);
        post();
        pre();
        chk("post_rst_busy", busy === 1'b1, int'(busy), 1);
        chk("post_rst_gid", gid === 2'd1, int'(gid), 1);
        post();
        repeat (6) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
